// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- memory-access pipeline stage between execute and writeback.
//
// Takes the execute payload, picks either the synchronous data SRAM read data
// (for loads) or the ALU result, and offers the result to writeback and to
// decode for hazard detection and bypass. SRAM read data is only valid in
// the cycle after the address was issued, so a stalled load copies it into
// hold_data and keeps using that copy until the instruction leaves.
//
// Optional feature: define MEM_FWD_EN to carry final_result on mem_to_id_bus
// so decode can bypass from this stage. Without it that field reads zero and
// decode can use the bus only for hazard stalls.
//
// Ports:
//   clk              in   clock, all state updates on the rising edge
//   resetn           in   asynchronous active-low reset
//   mem_allowin      out  stage can accept from execute this cycle
//   ex_to_mem_valid  in   execute presents a valid instruction
//   ex_to_mem_bus    in   {pc, res_from_mem, rf_we, rf_waddr, alu_result, rkd_value}
//   wb_allowin       in   writeback can accept this cycle
//   mem_to_wb_valid  out  valid instruction offered to writeback
//   mem_to_wb_bus    out  {pc, rf_we, rf_waddr, final_result}
//   mem_to_id_bus    out  {rf_we, rf_waddr, final_result or zero}
//   data_sram_rdata  in   SRAM read data for the address issued last cycle
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int EX_BUS_W  = 103,
  parameter int WB_BUS_W  = 70,
  parameter int FWD_BUS_W = 38
) (
  input  logic                 clk,
  input  logic                 resetn,
  output logic                 mem_allowin,
  input  logic                 ex_to_mem_valid,
  input  logic [EX_BUS_W-1:0]  ex_to_mem_bus,
  input  logic                 wb_allowin,
  output logic                 mem_to_wb_valid,
  output logic [WB_BUS_W-1:0]  mem_to_wb_bus,
  output logic [FWD_BUS_W-1:0] mem_to_id_bus,
  input  logic [31:0]          data_sram_rdata
);

  logic                mem_valid;
  logic [EX_BUS_W-1:0] payload;
  logic                mem_first;
  logic [31:0]         hold_data;
  logic                hold_valid;

  logic [31:0] pc;
  logic        res_from_mem;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] alu_result;
  logic [31:0] rkd_value;
  logic        rf_we_qual;
  logic [31:0] load_data;
  logic [31:0] final_result;
  logic        accept;
  logic        leave;
  logic        capture;
  logic        unused_rkd;

  assign pc           = payload[102:71];
  assign res_from_mem = payload[70];
  assign rf_we        = payload[69];
  assign rf_waddr     = payload[68:64];
  assign alu_result   = payload[63:32];
  assign rkd_value    = payload[31:0];

  // rkd_value rides along for a future sub-word store/load extension.
  assign unused_rkd = ^rkd_value;

  // This stage never needs more than one cycle, so ready_go is constant 1.
  assign mem_allowin     = ~mem_valid | wb_allowin;
  assign mem_to_wb_valid = mem_valid;

  assign accept  = ex_to_mem_valid & mem_allowin;
  assign leave   = mem_valid & wb_allowin;
  // Only the first cycle's SRAM data belongs to this load; save it if we stall.
  assign capture = mem_valid & mem_first & res_from_mem & ~wb_allowin;

  // Result select: saved load data wins over live SRAM data once captured.
  always_comb begin
    load_data    = data_sram_rdata;
    final_result = alu_result;
    if (hold_valid) begin
      load_data = hold_data;
    end else begin
      load_data = data_sram_rdata;
    end
    if (res_from_mem) begin
      final_result = load_data;
    end else begin
      final_result = alu_result;
    end
  end

  // Bubbles must never look like a register write to decode or writeback.
  assign rf_we_qual    = mem_valid & rf_we;
  assign mem_to_wb_bus = {pc, rf_we_qual, rf_waddr, final_result};

`ifdef MEM_FWD_EN
  assign mem_to_id_bus = {rf_we_qual, rf_waddr, final_result};
`else
  assign mem_to_id_bus = {rf_we_qual, rf_waddr, 32'h0000_0000};
`endif

  // Pipeline valid/payload handshake plus load-data hold buffer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid  <= 1'b0;
      payload    <= {EX_BUS_W{1'b0}};
      mem_first  <= 1'b0;
      hold_data  <= 32'h0000_0000;
      hold_valid <= 1'b0;
    end else begin
      if (mem_allowin) begin
        mem_valid <= ex_to_mem_valid;
      end
      if (accept) begin
        payload <= ex_to_mem_bus;
      end
      mem_first <= accept;
      // capture implies ~wb_allowin, hence neither accept nor leave.
      if (accept || leave) begin
        hold_valid <= 1'b0;
      end else if (capture) begin
        hold_data  <= data_sram_rdata;
        hold_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage -- directed self-checking bench for mem_stage.
// Inputs change 1 time unit after a rising edge; outputs are compared 1 time
// unit after that, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  logic         clk;
  logic         resetn;
  logic         mem_allowin;
  logic         ex_to_mem_valid;
  logic [102:0] ex_to_mem_bus;
  logic         wb_allowin;
  logic         mem_to_wb_valid;
  logic [69:0]  mem_to_wb_bus;
  logic [37:0]  mem_to_id_bus;
  logic [31:0]  data_sram_rdata;

  int n_total;
  int n_pass;

  mem_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .mem_allowin     (mem_allowin),
    .ex_to_mem_valid (ex_to_mem_valid),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .wb_allowin      (wb_allowin),
    .mem_to_wb_valid (mem_to_wb_valid),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .mem_to_id_bus   (mem_to_id_bus),
    .data_sram_rdata (data_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic rfm,
                       input logic we, input logic [4:0] wa, input logic [31:0] alu);
    ex_to_mem_valid = v;
    ex_to_mem_bus   = {pc, rfm, we, wa, alu, 32'hA5A5_5A5A};
  endtask

  function automatic logic [69:0] wb_exp(input logic [31:0] pc, input logic we,
                                         input logic [4:0] wa, input logic [31:0] res);
    return {pc, we, wa, res};
  endfunction

  function automatic logic [37:0] id_exp(input logic we, input logic [4:0] wa,
                                         input logic [31:0] res);
`ifdef MEM_FWD_EN
    return {we, wa, res};
`else
    return {we, wa, 32'h0000_0000};
`endif
  endfunction

  initial begin
    n_total = 0;
    n_pass  = 0;
    ex_to_mem_valid = 1'b0;
    ex_to_mem_bus   = 103'd0;
    wb_allowin      = 1'b1;
    data_sram_rdata = 32'h0000_0000;

    // Asynchronous reset, no clock edge yet.
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #1;
    check("rst_valid",   mem_to_wb_valid, 1'b0);
    check("rst_allowin", mem_allowin, 1'b1);
    check("rst_id_bus",  mem_to_id_bus, 38'd0);
    check("rst_wb_bus",  mem_to_wb_bus, 70'd0);
    #2 resetn = 1'b1;

    // ALU pass-through.
    drive(1'b1, 32'h1C00_0010, 1'b0, 1'b1, 5'd5, 32'h1234_5678);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    check("alu_valid",  mem_to_wb_valid, 1'b1);
    check("alu_wb_bus", mem_to_wb_bus, wb_exp(32'h1C00_0010, 1'b1, 5'd5, 32'h1234_5678));
    check("alu_id_bus", mem_to_id_bus, id_exp(1'b1, 5'd5, 32'h1234_5678));
    tick();
    #1;
    check("bubble_valid", mem_to_wb_valid, 1'b0);
    check("bubble_wb_we", mem_to_wb_bus[37], 1'b0);
    check("bubble_id_we", mem_to_id_bus[37], 1'b0);

    // Load without stall.
    drive(1'b1, 32'h1C00_0020, 1'b1, 1'b1, 5'd7, 32'h0000_0100);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    data_sram_rdata = 32'hDEAD_BEEF;
    #1;
    check("ld_wb_bus", mem_to_wb_bus, wb_exp(32'h1C00_0020, 1'b1, 5'd7, 32'hDEAD_BEEF));
    tick();
    data_sram_rdata = 32'h0000_0000;
    #1;
    check("ld_left", mem_to_wb_valid, 1'b0);

    // Load stalled 3 cycles; a younger ALU op waits upstream meanwhile.
    drive(1'b1, 32'h1C00_0030, 1'b1, 1'b1, 5'd7, 32'h0000_0200);
    tick();
    drive(1'b1, 32'h1C00_0050, 1'b0, 1'b1, 5'd9, 32'h0000_0055);
    data_sram_rdata = 32'hDEAD_BEEF;
    wb_allowin = 1'b0;
    #1;
    check("stall1_wb_bus",  mem_to_wb_bus, wb_exp(32'h1C00_0030, 1'b1, 5'd7, 32'hDEAD_BEEF));
    check("stall1_allowin", mem_allowin, 1'b0);
    tick();
    data_sram_rdata = 32'h0000_0000;
    #1;
    check("stall2_wb_bus",  mem_to_wb_bus, wb_exp(32'h1C00_0030, 1'b1, 5'd7, 32'hDEAD_BEEF));
    check("stall2_allowin", mem_allowin, 1'b0);
    tick();
    data_sram_rdata = 32'hFFFF_FFFF;
    #1;
    check("stall3_wb_bus", mem_to_wb_bus, wb_exp(32'h1C00_0030, 1'b1, 5'd7, 32'hDEAD_BEEF));
    check("stall3_id_bus", mem_to_id_bus, id_exp(1'b1, 5'd7, 32'hDEAD_BEEF));
    tick();
    wb_allowin = 1'b1;
    data_sram_rdata = 32'h1212_1212;
    #1;
    check("exit_wb_bus",  mem_to_wb_bus, wb_exp(32'h1C00_0030, 1'b1, 5'd7, 32'hDEAD_BEEF));
    check("exit_allowin", mem_allowin, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    check("waiter_wb_bus", mem_to_wb_bus, wb_exp(32'h1C00_0050, 1'b1, 5'd9, 32'h0000_0055));

    // Fresh load right after a stalled one: must use live SRAM data.
    drive(1'b1, 32'h1C00_0040, 1'b1, 1'b1, 5'd3, 32'h0000_0300);
    tick();
    drive(1'b1, 32'h1C00_0100, 1'b0, 1'b1, 5'd1, 32'h0000_0001);
    data_sram_rdata = 32'hCAFE_F00D;
    #1;
    check("fwd_wb_bus", mem_to_wb_bus, wb_exp(32'h1C00_0040, 1'b1, 5'd3, 32'hCAFE_F00D));
    check("fwd_id_bus", mem_to_id_bus, id_exp(1'b1, 5'd3, 32'hCAFE_F00D));

    // Back-to-back: load leaves while A enters, then B, C, then a gap.
    tick();
    drive(1'b1, 32'h1C00_0104, 1'b0, 1'b1, 5'd2, 32'h0000_0002);
    #1;
    check("b2b_a", mem_to_wb_bus, wb_exp(32'h1C00_0100, 1'b1, 5'd1, 32'h0000_0001));
    tick();
    drive(1'b1, 32'h1C00_0108, 1'b0, 1'b1, 5'd3, 32'h0000_0003);
    #1;
    check("b2b_b", mem_to_wb_bus, wb_exp(32'h1C00_0104, 1'b1, 5'd2, 32'h0000_0002));
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    check("b2b_c",       mem_to_wb_bus, wb_exp(32'h1C00_0108, 1'b1, 5'd3, 32'h0000_0003));
    check("b2b_c_valid", mem_to_wb_valid, 1'b1);
    tick();
    #1;
    check("gap_valid", mem_to_wb_valid, 1'b0);
    check("gap_wb_we", mem_to_wb_bus[37], 1'b0);

    // Reset in the middle of a stalled load with captured data.
    drive(1'b1, 32'h1C00_0060, 1'b1, 1'b1, 5'd4, 32'h0000_0400);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    wb_allowin = 1'b0;
    data_sram_rdata = 32'h1111_1111;
    tick();
    #1;
    resetn = 1'b0;
    #1;
    check("midrst_valid",   mem_to_wb_valid, 1'b0);
    check("midrst_allowin", mem_allowin, 1'b1);
    check("midrst_wb_bus",  mem_to_wb_bus, 70'd0);
    #1 resetn = 1'b1;
    wb_allowin = 1'b1;
    drive(1'b1, 32'h1C00_0070, 1'b1, 1'b1, 5'd2, 32'h0000_0700);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    data_sram_rdata = 32'h2222_2222;
    #1;
    check("postrst_ld", mem_to_wb_bus, wb_exp(32'h1C00_0070, 1'b1, 5'd2, 32'h2222_2222));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
